// File: rtl/bip_run_ctrl.sv
// Run/step/dump sequencer for the BIP core: gates cpu execution, counts executed cycles,
// and streams data memory to a host byte link over valid/ready.
module bip_run_ctrl #(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16,
  parameter int CELDAS  = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_cmd_run,
  input  logic               i_cmd_step,
  input  logic               i_cmd_dump,
  input  logic               i_cpu_halt,
  input  logic               i_cpu_rd,
  input  logic               i_cpu_wr,
  input  logic [NBITS_O-1:0] i_cpu_addr,
  input  logic [NBITS_D-1:0] i_cpu_data,
  input  logic [NBITS_D-1:0] i_dm_data,
  output logic               o_cpu_en,
  output logic               o_dm_rd,
  output logic               o_dm_wr,
  output logic [NBITS_O-1:0] o_dm_addr,
  output logic [NBITS_D-1:0] o_dm_data,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic [NBITS_D-1:0] o_cycles,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0, RUN = 3'd1, STEP = 3'd2, HALTED = 3'd3,
    DRD  = 3'd4, DCAP = 3'd5, DHI = 3'd6, DLO = 3'd7
  } state_t;

  localparam logic [NBITS_O-1:0] LAST_ADDR = NBITS_O'(CELDAS - 1);
  localparam logic [NBITS_D-1:0] CYC_MAX   = '1;

  state_t             state, state_nxt;
  logic               ret_halted, ret_halted_nxt;
  logic [NBITS_O-1:0] addr, addr_nxt;
  logic [15:0]        word, word_nxt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      ret_halted <= 1'b0;
      addr       <= '0;
      word       <= '0;
      o_cycles   <= '0;
    end else begin
      state      <= state_nxt;
      ret_halted <= ret_halted_nxt;
      addr       <= addr_nxt;
      word       <= word_nxt;
      if (o_cpu_en && o_cycles != CYC_MAX) o_cycles <= o_cycles + 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    ret_halted_nxt = ret_halted;
    addr_nxt       = addr;
    word_nxt       = word;
    case (state)
      IDLE: begin
        if (i_cmd_dump) begin
          state_nxt      = DRD;
          addr_nxt       = '0;
          ret_halted_nxt = 1'b0;
        end else if (i_cmd_step) state_nxt = STEP;
        else if (i_cmd_run)      state_nxt = RUN;
      end
      RUN:  if (i_cpu_halt) state_nxt = HALTED;
      STEP: state_nxt = i_cpu_halt ? HALTED : IDLE;
      // A halted core can only be inspected; restarting it takes a reset.
      HALTED: begin
        if (i_cmd_dump) begin
          state_nxt      = DRD;
          addr_nxt       = '0;
          ret_halted_nxt = 1'b1;
        end
      end
      DRD:  state_nxt = DCAP;
      DCAP: begin
        word_nxt  = 16'(i_dm_data);
        state_nxt = DHI;
      end
      DHI:  if (i_tx_ready) state_nxt = DLO;
      DLO: begin
        if (i_tx_ready) begin
          if (addr == LAST_ADDR) state_nxt = ret_halted ? HALTED : IDLE;
          else begin
            addr_nxt  = addr + 1'b1;
            state_nxt = DRD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_cpu_en = (state == STEP) || (state == RUN && !i_cpu_halt);

  // The cpu only reaches memory while enabled; the dump owns the port in DRD.
  always_comb begin
    o_dm_rd   = 1'b0;
    o_dm_wr   = 1'b0;
    o_dm_addr = '0;
    o_dm_data = '0;
    if (o_cpu_en) begin
      o_dm_rd   = i_cpu_rd;
      o_dm_wr   = i_cpu_wr;
      o_dm_addr = i_cpu_addr;
      o_dm_data = i_cpu_data;
    end else if (state == DRD) begin
      o_dm_rd   = 1'b1;
      o_dm_addr = addr;
    end
  end

  assign o_tx_valid = (state == DHI) || (state == DLO);
  assign o_tx_data  = (state == DHI) ? word[15:8] :
                      (state == DLO) ? word[7:0]  : 8'h00;
  assign o_state    = state;

endmodule
